frame_bank_scheduler: RTL

Double-buffer controller for the 1-bit 200x150 video buffer. It accepts a pixel stream from the SPI frame loader over a valid/ready handshake and generates write addresses into the back bank. At a vertical-blanking boundary it swaps front/back banks, but only when a complete frame has been written and the frame-rate divider ticks. It sits between the SPI deserializer and the video buffer write port, beside the sync generators on the CLK_40 pixel clock.

---
 rtl/frame_bank_scheduler.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/frame_bank_scheduler.sv
// Double-buffer write scheduler: streams pixels into the back bank, swaps banks on a divided v-blank edge.
// Optional FRAME_STATS_EN macro enables the repeat/resync statistics counters.
module frame_bank_scheduler #(
  parameter int WIDTH     = 200,
  parameter int HEIGHT    = 150,
  parameter int FRAME_DIV = 4,
  parameter int X_W       = 8,
  parameter int Y_W       = 8
) (
  input  logic           CLK_40,
  input  logic           reset_n,
  input  logic           v_BLANK,
  input  logic           pix_valid,
  input  logic           pix_sof,
  input  logic           pix_data,
  output logic           pix_ready,
  output logic           wr_en,
  output logic [X_W-1:0] wr_x,
  output logic [Y_W-1:0] wr_y,
  output logic           wr_data,
  output logic           wr_bank,
  output logic           rd_bank,
  output logic           swap,
  output logic [15:0]    repeat_cnt,
  output logic [15:0]    resync_cnt
);

  localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_READY
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic             r_vb_q;
  logic [DIV_W-1:0] r_div;
  logic [X_W-1:0]   r_x;
  logic [Y_W-1:0]   r_y;
  logic             r_wr_en;
  logic [X_W-1:0]   r_wr_x;
  logic [Y_W-1:0]   r_wr_y;
  logic             r_wr_data;
  logic             r_rd_bank;
  logic             r_swap;

  logic w_ready;
  logic w_accept;
  logic w_vb_edge;
  logic w_div_end;
  logic w_tick;
  logic w_x_end;
  logic w_y_end;
  logic w_fire;
  logic w_restart;
  logic w_swap_go;

  assign w_ready   = (r_state != S_READY);
  assign w_accept  = pix_valid & w_ready;
  assign w_vb_edge = v_BLANK & ~r_vb_q;
  assign w_div_end = (r_div == DIV_W'(FRAME_DIV - 1));
  assign w_tick    = w_vb_edge & w_div_end;
  assign w_x_end   = (r_x == X_W'(WIDTH - 1));
  assign w_y_end   = (r_y == Y_W'(HEIGHT - 1));
  assign w_swap_go = (r_state == S_READY) & w_tick;

  always_ff @(posedge CLK_40) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // SOF always wins over the last-pixel position, so the frame restarts instead of completing.
  always_comb begin
    w_state_nxt = r_state;
    w_fire      = 1'b0;
    w_restart   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept && pix_sof) begin
          w_fire      = 1'b1;
          w_restart   = 1'b1;
          w_state_nxt = S_FILL;
        end
      end
      S_FILL: begin
        if (w_accept) begin
          w_fire = 1'b1;
          if (pix_sof) begin
            w_restart = 1'b1;
          end else if (w_x_end && w_y_end) begin
            w_state_nxt = S_READY;
          end
        end
      end
      S_READY: begin
        if (w_tick) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_40) begin
    if (!reset_n) begin
      r_vb_q    <= 1'b1;
      r_div     <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_wr_en   <= 1'b0;
      r_wr_x    <= '0;
      r_wr_y    <= '0;
      r_wr_data <= 1'b0;
      r_rd_bank <= 1'b0;
      r_swap    <= 1'b0;
    end else begin
      r_vb_q  <= v_BLANK;
      r_wr_en <= w_fire;
      r_swap  <= w_swap_go;
      if (w_vb_edge) begin
        r_div <= w_div_end ? '0 : r_div + DIV_W'(1);
      end
      if (w_fire) begin
        r_wr_x    <= w_restart ? '0 : r_x;
        r_wr_y    <= w_restart ? '0 : r_y;
        r_wr_data <= pix_data;
      end
      if (w_restart) begin
        r_x <= X_W'(1);
        r_y <= '0;
      end else if (w_fire) begin
        if (w_x_end) begin
          r_x <= '0;
          r_y <= w_y_end ? '0 : r_y + Y_W'(1);
        end else begin
          r_x <= r_x + X_W'(1);
        end
      end
      if (w_swap_go) begin
        r_rd_bank <= ~r_rd_bank;
      end
    end
  end

  assign pix_ready = w_ready;
  assign wr_en     = r_wr_en;
  assign wr_x      = r_wr_x;
  assign wr_y      = r_wr_y;
  assign wr_data   = r_wr_data;
  assign rd_bank   = r_rd_bank;
  assign wr_bank   = ~r_rd_bank;
  assign swap      = r_swap;

`ifdef FRAME_STATS_EN
  logic        w_repeat;
  logic        w_resync;
  logic [15:0] r_repeat_cnt;
  logic [15:0] r_resync_cnt;

  assign w_repeat = w_tick & (r_state != S_READY);
  assign w_resync = (r_state == S_FILL) & w_accept & pix_sof;

  always_ff @(posedge CLK_40) begin
    if (!reset_n) begin
      r_repeat_cnt <= '0;
      r_resync_cnt <= '0;
    end else begin
      if (w_repeat && (r_repeat_cnt != '1)) begin
        r_repeat_cnt <= r_repeat_cnt + 16'd1;
      end
      if (w_resync && (r_resync_cnt != '1)) begin
        r_resync_cnt <= r_resync_cnt + 16'd1;
      end
    end
  end

  assign repeat_cnt = r_repeat_cnt;
  assign resync_cnt = r_resync_cnt;
`else
  assign repeat_cnt = '0;
  assign resync_cnt = '0;
`endif

endmodule
